// File: rtl/reg_status_file_if.sv
// Commit, dispatch and operand-lookup bundle between the ROB/dispatch side
// and the register status file. Lane 0 occupies the most-significant slice of each flat bus.
interface reg_status_file_if #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4
);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int CNT_W   = $clog2(NUM_REGS + 1);
    localparam int NUM_LN  = 4;
    localparam int NUM_SRC = 2 * NUM_LN;

    logic [NUM_LN-1:0]          commit_we_flat;
    logic [NUM_LN*IDX_W-1:0]    commit_target_flat;
    logic [NUM_LN*DATA_W-1:0]   commit_data_flat;
    logic [NUM_LN*TAG_W-1:0]    commit_writer_flat;
    logic                       flush;
    logic [NUM_LN-1:0]          alloc_valid_flat;
    logic [NUM_LN*IDX_W-1:0]    alloc_target_flat;
    logic [TAG_W-1:0]           rob_head;
    logic [NUM_SRC*IDX_W-1:0]   src_reg_flat;
    logic [NUM_SRC-1:0]         src_ready_flat;
    logic [NUM_SRC*DATA_W-1:0]  src_value_flat;
    logic [NUM_SRC*TAG_W-1:0]   src_tag_flat;
    logic [CNT_W-1:0]           busy_count;

    modport master (
        output commit_we_flat, commit_target_flat, commit_data_flat, commit_writer_flat,
        output flush, alloc_valid_flat, alloc_target_flat, rob_head, src_reg_flat,
        input  src_ready_flat, src_value_flat, src_tag_flat, busy_count
    );

    modport slave (
        input  commit_we_flat, commit_target_flat, commit_data_flat, commit_writer_flat,
        input  flush, alloc_valid_flat, alloc_target_flat, rob_head, src_reg_flat,
        output src_ready_flat, src_value_flat, src_tag_flat, busy_count
    );
endinterface

// File: rtl/reg_status_file.sv
// Architectural register file with rename-status table: ROB commits write values,
// dispatch allocates tags, eight source lookups per cycle return value or tag.
module reg_status_file #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 4
) (
    input logic               clk,
    input logic               rst,
    reg_status_file_if.slave  bus
);
    localparam int IDX_W   = $clog2(NUM_REGS);
    localparam int CNT_W   = $clog2(NUM_REGS + 1);
    localparam int NUM_LN  = 4;
    localparam int NUM_SRC = 2 * NUM_LN;

    logic [DATA_W-1:0]   value_q [NUM_REGS];
    logic [TAG_W-1:0]    tag_q   [NUM_REGS];
    logic [TAG_W-1:0]    tag_d   [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    busy_count_q, busy_count_d;

    logic                c_we   [NUM_LN];
    logic [IDX_W-1:0]    c_tgt  [NUM_LN];
    logic [DATA_W-1:0]   c_data [NUM_LN];
    logic [TAG_W-1:0]    c_wr   [NUM_LN];
    logic                a_vld  [NUM_LN];
    logic [IDX_W-1:0]    a_tgt  [NUM_LN];
    logic [TAG_W-1:0]    a_tag  [NUM_LN];
    logic [TAG_W-1:0]    run_tag;

    always_comb begin
        run_tag = bus.rob_head;
        for (int unsigned i = 0; i < NUM_LN; i++) begin
            c_we[i]   = bus.commit_we_flat[NUM_LN-1-i];
            c_tgt[i]  = bus.commit_target_flat[(NUM_LN-1-i)*IDX_W +: IDX_W];
            c_data[i] = bus.commit_data_flat[(NUM_LN-1-i)*DATA_W +: DATA_W];
            c_wr[i]   = bus.commit_writer_flat[(NUM_LN-1-i)*TAG_W +: TAG_W];
            a_vld[i]  = bus.alloc_valid_flat[NUM_LN-1-i];
            a_tgt[i]  = bus.alloc_target_flat[(NUM_LN-1-i)*IDX_W +: IDX_W];
            // Valid lanes take consecutive ROB slots; invalid lanes consume none.
            a_tag[i]  = run_tag;
            if (a_vld[i])
                run_tag = run_tag + TAG_W'(1);
        end
    end

    // Later assignments override earlier ones: commit clear, then flush or allocation.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            tag_d[r] = tag_q[r];
        for (int unsigned i = 0; i < NUM_LN; i++) begin
            if (c_we[i] && busy_q[c_tgt[i]] && (tag_q[c_tgt[i]] == c_wr[i]))
                busy_d[c_tgt[i]] = 1'b0;
        end
        if (bus.flush) begin
            busy_d = '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LN; i++) begin
                if (a_vld[i]) begin
                    busy_d[a_tgt[i]] = 1'b1;
                    tag_d[a_tgt[i]]  = a_tag[i];
                end
            end
        end
        busy_count_d = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++)
            busy_count_d = busy_count_d + CNT_W'(busy_d[r]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q       <= '0;
            busy_count_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
        end else begin
            busy_q       <= busy_d;
            busy_count_q <= busy_count_d;
            for (int unsigned r = 0; r < NUM_REGS; r++)
                tag_q[r] <= tag_d[r];
            for (int unsigned i = 0; i < NUM_LN; i++) begin
                if (c_we[i])
                    value_q[c_tgt[i]] <= c_data[i];
            end
        end
    end

    // Table lookup, then override by the nearest earlier lane allocating the same register.
    always_comb begin
        logic [IDX_W-1:0] sreg;
        bus.src_ready_flat = '0;
        bus.src_value_flat = '0;
        bus.src_tag_flat   = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            sreg = bus.src_reg_flat[(NUM_SRC-1-k)*IDX_W +: IDX_W];
            bus.src_ready_flat[NUM_SRC-1-k]                = ~busy_q[sreg];
            bus.src_value_flat[(NUM_SRC-1-k)*DATA_W +: DATA_W] = value_q[sreg];
            bus.src_tag_flat[(NUM_SRC-1-k)*TAG_W +: TAG_W]     = tag_q[sreg];
            for (int unsigned j = 0; j < NUM_LN; j++) begin
                if ((j < k / 2) && a_vld[j] && (a_tgt[j] == sreg)) begin
                    bus.src_ready_flat[NUM_SRC-1-k]            = 1'b0;
                    bus.src_tag_flat[(NUM_SRC-1-k)*TAG_W +: TAG_W] = a_tag[j];
                end
            end
        end
    end

    assign bus.busy_count = busy_count_q;
endmodule

// File: tb/tb_reg_status_file.sv
// Directed and random checks of reg_status_file against an array-based reference model.
module tb_reg_status_file;
    localparam int NR = 16;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int NL = 4;
    localparam int NS = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_status_file_if #(.NUM_REGS(NR), .DATA_W(DW), .TAG_W(TW)) bus ();
    reg_status_file #(.NUM_REGS(NR), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    bit          c_we   [NL];
    int unsigned c_tgt  [NL];
    int unsigned c_data [NL];
    int unsigned c_wr   [NL];
    bit          a_v    [NL];
    int unsigned a_tgt  [NL];
    int unsigned head;
    bit          fl;
    int unsigned src    [NS];

    int unsigned m_val  [NR];
    int unsigned m_tag  [NR];
    bit          m_busy [NR];

    int checks   = 0;
    int failures = 0;

    task automatic idle();
        for (int i = 0; i < NL; i++) begin
            c_we[i] = 0; c_tgt[i] = 0; c_data[i] = 0; c_wr[i] = 0;
            a_v[i] = 0; a_tgt[i] = 0;
        end
        head = 0; fl = 0;
        for (int k = 0; k < NS; k++) src[k] = k;
    endtask

    task automatic drive();
        for (int i = 0; i < NL; i++) begin
            bus.commit_we_flat[NL-1-i]              = c_we[i];
            bus.commit_target_flat[(NL-1-i)*4 +: 4] = 4'(c_tgt[i]);
            bus.commit_data_flat[(NL-1-i)*DW +: DW] = 16'(c_data[i]);
            bus.commit_writer_flat[(NL-1-i)*TW +: TW] = 4'(c_wr[i]);
            bus.alloc_valid_flat[NL-1-i]            = a_v[i];
            bus.alloc_target_flat[(NL-1-i)*4 +: 4]  = 4'(a_tgt[i]);
        end
        bus.rob_head = 4'(head);
        bus.flush    = fl;
        for (int k = 0; k < NS; k++)
            bus.src_reg_flat[(NS-1-k)*4 +: 4] = 4'(src[k]);
    endtask

    function automatic int unsigned lane_tag(int lane);
        int unsigned n = 0;
        for (int j = 0; j < lane; j++)
            if (a_v[j]) n++;
        return (head + n) % 16;
    endfunction

    function automatic logic [31:0] obs_rdy(int k);
        return 32'(bus.src_ready_flat[NS-1-k]);
    endfunction
    function automatic logic [31:0] obs_val(int k);
        return 32'(bus.src_value_flat[(NS-1-k)*DW +: DW]);
    endfunction
    function automatic logic [31:0] obs_tag(int k);
        return 32'(bus.src_tag_flat[(NS-1-k)*TW +: TW]);
    endfunction

    task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_lookups();
        int unsigned n_busy = 0;
        for (int k = 0; k < NS; k++) begin
            bit          e_rdy;
            int unsigned e_tag;
            bit          found = 0;
            for (int j = k / 2 - 1; j >= 0; j--) begin
                if (!found && a_v[j] && a_tgt[j] == src[k]) begin
                    found = 1;
                    e_tag = lane_tag(j);
                end
            end
            if (found) e_rdy = 0;
            else begin
                e_rdy = !m_busy[src[k]];
                e_tag = m_tag[src[k]];
            end
            chk($sformatf("ready[%0d] r%0d", k, src[k]), obs_rdy(k), 32'(e_rdy));
            if (e_rdy) chk($sformatf("value[%0d] r%0d", k, src[k]), obs_val(k), m_val[src[k]]);
            else       chk($sformatf("tag[%0d] r%0d", k, src[k]), obs_tag(k), e_tag);
        end
        for (int r = 0; r < NR; r++) if (m_busy[r]) n_busy++;
        chk("busy_count", 32'(bus.busy_count), n_busy);
    endtask

    task automatic model_edge();
        int unsigned nv [NR];
        int unsigned nt [NR];
        bit          nb [NR];
        bit          taken [NR];
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_val[r] = 0; m_tag[r] = 0; m_busy[r] = 0;
            end
            return;
        end
        for (int r = 0; r < NR; r++) begin
            nv[r] = m_val[r]; nt[r] = m_tag[r]; nb[r] = m_busy[r]; taken[r] = 0;
        end
        for (int i = 0; i < NL; i++)
            if (!fl && a_v[i]) taken[a_tgt[i]] = 1;
        for (int i = 0; i < NL; i++) begin
            if (c_we[i]) begin
                nv[c_tgt[i]] = c_data[i] & 16'hFFFF;
                if (m_busy[c_tgt[i]] && m_tag[c_tgt[i]] == c_wr[i] && !taken[c_tgt[i]])
                    nb[c_tgt[i]] = 0;
            end
        end
        if (fl) begin
            for (int r = 0; r < NR; r++) nb[r] = 0;
        end else begin
            for (int i = 0; i < NL; i++)
                if (a_v[i]) begin
                    nb[a_tgt[i]] = 1;
                    nt[a_tgt[i]] = lane_tag(i);
                end
        end
        for (int r = 0; r < NR; r++) begin
            m_val[r] = nv[r]; m_tag[r] = nt[r]; m_busy[r] = nb[r];
        end
    endtask

    task automatic step(bit do_chk);
        drive();
        #1;
        if (do_chk) check_lookups();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // Look at sources without changing state; the next step follows before the edge.
    task automatic peek(int unsigned r0, int unsigned r1, int unsigned r2, int unsigned r3);
        idle();
        src[0] = r0; src[1] = r1; src[2] = r2; src[3] = r3;
        drive();
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        step(0);
        step(0);
        rst = 0;

        // Reset state
        idle();
        step(1);
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("rst_ready r%0d", k), obs_rdy(k), 32'd1);
            chk($sformatf("rst_value r%0d", k), obs_val(k), 32'd0);
        end
        chk("rst_busy_count", 32'(bus.busy_count), 32'd0);

        // Allocation with wrapping tags and same-cycle override
        idle();
        head = 14;
        a_v[0] = 1; a_tgt[0] = 2;
        a_v[1] = 1; a_tgt[1] = 3;
        a_v[3] = 1; a_tgt[3] = 4;
        src[6] = 3;
        drive(); #1;
        chk("override_ready", obs_rdy(6), 32'd0);
        chk("override_tag", obs_tag(6), 32'd15);
        step(1);
        peek(2, 3, 4, 0);
        chk("tag_r2", obs_tag(0), 32'd14);
        chk("tag_r3", obs_tag(1), 32'd15);
        chk("tag_r4_wrap", obs_tag(2), 32'd0);
        chk("busy_count_3", 32'(bus.busy_count), 32'd3);

        // Matching commit clears; stale commit writes but stays busy
        idle();
        c_we[1] = 1; c_tgt[1] = 3; c_wr[1] = 15; c_data[1] = 16'hBEEF;
        c_we[2] = 1; c_tgt[2] = 4; c_wr[2] = 5;  c_data[2] = 16'h1234;
        step(1);
        peek(3, 4, 0, 0);
        chk("commit_r3_ready", obs_rdy(0), 32'd1);
        chk("commit_r3_value", obs_val(0), 32'hBEEF);
        chk("stale_r4_ready", obs_rdy(1), 32'd0);
        chk("stale_r4_tag", obs_tag(1), 32'd0);

        // Allocation beats same-cycle commit clear
        idle();
        c_we[0] = 1; c_tgt[0] = 2; c_wr[0] = 14; c_data[0] = 16'h5555;
        a_v[0] = 1; a_tgt[0] = 2; head = 6;
        step(1);
        peek(2, 0, 0, 0);
        chk("realloc_r2_ready", obs_rdy(0), 32'd0);
        chk("realloc_r2_tag", obs_tag(0), 32'd6);

        // Same-register collisions: highest lane wins
        idle();
        c_we[0] = 1; c_tgt[0] = 5; c_data[0] = 1;
        c_we[2] = 1; c_tgt[2] = 5; c_data[2] = 2;
        a_v[1] = 1; a_tgt[1] = 6;
        a_v[3] = 1; a_tgt[3] = 6;
        head = 0;
        step(1);
        peek(5, 6, 0, 0);
        chk("multi_commit_r5", obs_val(0), 32'd2);
        chk("multi_alloc_r6_tag", obs_tag(1), 32'd1);

        // Flush drops allocs, keeps commits
        idle();
        a_v[0] = 1; a_tgt[0] = 7;
        a_v[1] = 1; a_tgt[1] = 8;
        head = 2;
        step(1);
        peek(0, 0, 0, 0);
        chk("busy_count_5", 32'(bus.busy_count), 32'd5);
        idle();
        fl = 1;
        a_v[0] = 1; a_tgt[0] = 9;
        c_we[0] = 1; c_tgt[0] = 1; c_data[0] = 16'h0042; c_wr[0] = 3;
        src[0] = 0; src[1] = 1;
        step(1);
        peek(9, 1, 0, 0);
        chk("flush_busy_count", 32'(bus.busy_count), 32'd0);
        chk("flush_r9_ready", obs_rdy(0), 32'd1);
        chk("flush_r1_ready", obs_rdy(1), 32'd1);
        chk("flush_r1_value", obs_val(1), 32'h0042);

        // Every register renamed
        for (int c = 0; c < 4; c++) begin
            idle();
            head = 4 * c;
            for (int i = 0; i < NL; i++) begin
                a_v[i] = 1; a_tgt[i] = 4 * c + i;
            end
            step(1);
        end
        peek(0, 15, 0, 0);
        chk("busy_count_full", 32'(bus.busy_count), 32'd16);
        chk("full_r15_tag", obs_tag(1), 32'd15);
        idle();
        c_we[0] = 1; c_tgt[0] = 0; c_wr[0] = 0; c_data[0] = 16'hA5A5;
        step(1);
        peek(0, 0, 0, 0);
        chk("busy_count_15", 32'(bus.busy_count), 32'd15);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 99) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            head = $urandom_range(0, 15);
            for (int i = 0; i < NL; i++) begin
                c_we[i]   = $urandom_range(0, 1);
                c_tgt[i]  = $urandom_range(0, 15);
                c_data[i] = $urandom_range(0, 16'hFFFF);
                c_wr[i]   = ($urandom_range(0, 1) == 1) ? m_tag[c_tgt[i]] : $urandom_range(0, 15);
                a_v[i]    = ($urandom_range(0, 9) < 4);
                a_tgt[i]  = $urandom_range(0, 15);
            end
            for (int k = 0; k < NS; k++) src[k] = $urandom_range(0, 15);
            step(1);
            rst = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
